mips_multicycle: RTL and testbench
==================================

# mips_multicycle

Multi-cycle MIPS-subset processor core: the next generation of the single-cycle top. One instruction is executed over 3–5 states of a fetch/decode/execute/memory/write-back FSM, sharing one ALU and one adder. Instruction and data memories are internal and parametrised in depth. Retirement, register write-back and store traffic are exported on observation ports for the verification bench.

## Interface
- IM_DEPTH, 1024: instruction memory depth in 32-bit words (power of two).
- DM_DEPTH, 1024: data memory depth in 32-bit words (power of two).
- PC_RESET, 32'h0000_3000: PC value after reset and base address of IM.
---
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears PC, FSM, GRF, DM and outputs.
- im_we  in  1  IM load strobe; sampled on clk, any state.
- im_waddr  in  32  IM load byte address; word index = (im_waddr-PC_RESET)>>2 mod IM_DEPTH.
- im_wdata  in  32  IM load data.
- pc_o  out  32  PC of the instruction in flight.
- retire  out  1  one-cycle pulse in the last state of every instruction.
- wb_en  out  1  high in the cycle a GRF write commits; never for $0.
- wb_addr  out  5  GRF write index.
- wb_data  out  32  GRF write data.
- st_en  out  1  high in the cycle a DM store commits.
- st_addr  out  32  store byte address, low two bits forced 0.
- st_data  out  32  store data.

## Operation
- Instructions: addu, subu (R, funct 0x21/0x23), ori, lw, sw, beq, lui, j, plus jal, jr under MC_LINK_EN. Every other encoding, including sll 0 (nop), retires as no-op.
- States: FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH.
- FETCH: IR <= IM[pc index]; PC <= PC+4; PC4 register holds PC+4.
- DECODE: A <= GRF[rs], B <= GRF[rt]; ext computed (zero-ext for ori, sign-ext for lw/sw/beq).
- EXEC: R-type/ori/lui -> ALUOut, go WB. lw/sw -> ALUOut = A + sext(imm), go MEM. beq: if A==B, PC <= PC4 + (sext(imm)<<2); retire; go FETCH. j: PC <= {PC4[31:28], imm26, 2'b00}; retire. jal: same target, $31 <= PC4; retire. jr: PC <= A; retire. No-op: retire.
- MEM: sw -> DM[word] <= B, st_en, retire, go FETCH. lw -> MDR <= DM[word], go WB.
- WB: rd (R-type) or rt (ori/lui/lw) <= ALUOut or MDR; retire.
- Latency in cycles: beq/j/jal/jr/no-op 3; addu/subu/ori/lui/sw 4; lw 5.
- Arithmetic is 32-bit modulo 2^32, no overflow trap. lui = imm<<16.
- DM word index = addr[log2(DM_DEPTH)+1:2]. Addresses wrap modulo depth. No unaligned check.
- GRF $0 reads 0. Writes to $0 are discarded and wb_en stays low.

## Timing
- Reset values: pc_o = PC_RESET; retire, wb_en, st_en = 0; wb_addr, wb_data, st_addr, st_data = 0; FSM = FETCH; GRF and DM all 0. IM contents are not cleared.
- Reset asserted mid-instruction aborts it with no partial write. The first FETCH follows the first rising clk after reset deasserts.
- IM reads combinationally from PC and is latched at the FETCH edge. An im_we to the word being fetched in the same cycle returns the old data.
- GRF and DM writes commit on the rising edge ending the WB or MEM state. Observation outputs are combinational from that state's values, so they are valid in the same cycle.
- GRF is read in DECODE. The previous instruction's write has already committed, so no hazard exists.
- retire is never high in two consecutive cycles.

## Configuration
- MC_LINK_EN defined: jal (op 0x03) and jr (op 0, funct 0x08) are executed as above.
- MC_LINK_EN undefined: both decode as no-op. They still retire in 3 cycles, $31 is untouched, and PC advances to PC+4.

## Test plan
- Reset: hold reset 3 cycles, then release -> pc_o=0x3000, all outputs 0, first retire at cycle 3 (no-op) or later.
- ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2 -> wb $1=0x00001234, $2=0xABCD0000, $3=0xABCD1234; retires spaced 4 cycles.
- sw $3,8($0); lw $4,8($0) -> st_en st_addr=0x8 st_data=0xABCD1234, then wb $4=0xABCD1234 after 5 cycles.
- beq $1,$1,-1 at 0x3010 -> PC loops at 0x3010, retire every 3 cycles. beq $1,$0 -> falls through to 0x3014.
- jal 0x3100 then jr $31 (MC_LINK_EN) -> wb $31=PC+4, pc_o=0x3100, then back to the return address. Without the macro -> two no-ops, no wb_en.
- Reset asserted in the MEM state of sw -> no st_en, DM word unchanged (0), pc_o=0x3000.

Source files
------------

// File: rtl/mips_multicycle_if.sv
// rtl/mips_multicycle_if.sv - IM load port and retirement/write-back/store observation bundle
//
// Signals:
//   im_we, im_waddr, im_wdata : instruction memory load strobe, byte address, data
//   pc_o                      : PC of the instruction in flight
//   retire                    : one-cycle pulse in the last state of each instruction
//   wb_en, wb_addr, wb_data   : register file write committing this cycle
//   st_en, st_addr, st_data   : data memory store committing this cycle
// Modports:
//   master : environment side (drives IM loads, observes the core)
//   slave  : core side
interface mips_multicycle_if;
    logic        im_we;
    logic [31:0] im_waddr;
    logic [31:0] im_wdata;
    logic [31:0] pc_o;
    logic        retire;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        st_en;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    modport master (
        output im_we, im_waddr, im_wdata,
        input  pc_o, retire, wb_en, wb_addr, wb_data, st_en, st_addr, st_data
    );

    modport slave (
        input  im_we, im_waddr, im_wdata,
        output pc_o, retire, wb_en, wb_addr, wb_data, st_en, st_addr, st_data
    );
endinterface

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multi-cycle MIPS-subset core with internal IM/DM
//
// Parameters: IM_DEPTH / DM_DEPTH (words, power of two), PC_RESET (reset PC and IM base).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (clears PC, FSM, GRF, DM; IM keeps contents)
//   bus   : mips_multicycle_if.slave - IM load port plus retire/write-back/store observation
// Optional feature: define MC_LINK_EN to execute jal and jr; otherwise both retire as no-ops.
module mips_multicycle #(
    parameter int          IM_DEPTH = 1024,
    parameter int          DM_DEPTH = 1024,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_if.slave      bus
);
    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int DM_AW = $clog2(DM_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t state;
    state_t state_n;

    logic [31:0] im [IM_DEPTH];
    logic [31:0] dm [DM_DEPTH];
    logic [31:0] grf [32];

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ir_pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_out;
    logic [31:0] mdr;

    // Instruction fields
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign imm          = ir[15:0];
    assign unused_shamt = ^ir[10:6];

    logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal, is_jr;
    logic reg_op;
    logic mem_op;

    assign is_addu = (op == 6'h00) && (funct == 6'h21);
    assign is_subu = (op == 6'h00) && (funct == 6'h23);
    assign is_ori  = (op == 6'h0d);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2b);
    assign is_beq  = (op == 6'h04);
    assign is_lui  = (op == 6'h0f);
    assign is_j    = (op == 6'h02);
`ifdef MC_LINK_EN
    assign is_jal  = (op == 6'h03);
    assign is_jr   = (op == 6'h00) && (funct == 6'h08);
`else
    assign is_jal  = 1'b0;
    assign is_jr   = 1'b0;
`endif

    assign reg_op = is_addu | is_subu | is_ori | is_lui;
    assign mem_op = is_lw | is_sw;

    logic [31:0] ext;
    logic [31:0] alu_res;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [4:0]  dest;
    logic [DM_AW-1:0] dm_idx;
    logic [IM_AW-1:0] im_ridx;
    logic [IM_AW-1:0] im_widx;

    assign ext       = is_ori ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign br_target = pc4 + {ext[29:0], 2'b00};
    assign j_target  = {pc4[31:28], ir[25:0], 2'b00};
    assign dest      = (is_addu | is_subu) ? rd : rt;
    assign dm_idx    = alu_out[DM_AW+1:2];
    // IM is based at PC_RESET; word index wraps modulo the depth
    assign im_ridx   = IM_AW'((pc - PC_RESET) >> 2);
    assign im_widx   = IM_AW'((bus.im_waddr - PC_RESET) >> 2);

    always_comb begin
        alu_res = 32'h0;
        if (is_addu)     alu_res = a + b;
        else if (is_subu) alu_res = a - b;
        else if (is_ori)  alu_res = a | ext;
        else if (is_lui)  alu_res = {imm, 16'h0000};
        else if (mem_op)  alu_res = a + ext;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // FSM: next state
    always_comb begin
        state_n = state;
        case (state)
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                if (reg_op)      state_n = S_WB;
                else if (mem_op) state_n = S_MEM;
                else             state_n = S_FETCH;
            end
            S_MEM:    state_n = is_lw ? S_WB : S_FETCH;
            S_WB:     state_n = S_FETCH;
            default:  state_n = S_FETCH;
        endcase
    end

    // FSM: outputs. Commits happen on the edge that ends the state, so these
    // combinational values are what the datapath writes.
    logic        retire_c;
    logic        wb_en_c;
    logic [4:0]  wb_addr_c;
    logic [31:0] wb_data_c;
    logic        st_en_c;

    always_comb begin
        retire_c  = 1'b0;
        wb_en_c   = 1'b0;
        wb_addr_c = 5'd0;
        wb_data_c = 32'h0;
        st_en_c   = 1'b0;
        case (state)
            S_EXEC: begin
                if (!reg_op && !mem_op) begin
                    retire_c = 1'b1;
                    if (is_jal) begin
                        wb_en_c   = 1'b1;
                        wb_addr_c = 5'd31;
                        wb_data_c = pc4;
                    end
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    retire_c = 1'b1;
                    st_en_c  = 1'b1;
                end
            end
            S_WB: begin
                retire_c = 1'b1;
                if (dest != 5'd0) begin
                    wb_en_c   = 1'b1;
                    wb_addr_c = dest;
                    wb_data_c = is_lw ? mdr : alu_out;
                end
            end
            default: ;
        endcase
    end

    // IM is load-only from outside and survives reset
    always_ff @(posedge clk) begin
        if (bus.im_we) im[im_widx] <= bus.im_wdata;
    end

    // Datapath registers, GRF and DM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= PC_RESET;
            pc4     <= PC_RESET;
            ir_pc   <= PC_RESET;
            ir      <= 32'h0;
            a       <= 32'h0;
            b       <= 32'h0;
            alu_out <= 32'h0;
            mdr     <= 32'h0;
            for (int i = 0; i < 32; i++) grf[i] <= 32'h0;
            for (int i = 0; i < DM_DEPTH; i++) dm[i] <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= im[im_ridx];
                    ir_pc <= pc;
                    pc    <= pc + 32'd4;
                    pc4   <= pc + 32'd4;
                end
                S_DECODE: begin
                    a <= grf[rs];
                    b <= grf[rt];
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq && (a == b)) pc <= br_target;
                    if (is_j || is_jal)     pc <= j_target;
                    if (is_jr)              pc <= a;
                end
                S_MEM: begin
                    if (is_lw) mdr <= dm[dm_idx];
                end
                default: ;
            endcase
            // $0 is never written, so its reset value keeps it reading 0
            if (wb_en_c) grf[wb_addr_c] <= wb_data_c;
            if (st_en_c) dm[dm_idx] <= b;
        end
    end

    assign bus.pc_o    = (state == S_FETCH) ? pc : ir_pc;
    assign bus.retire  = retire_c;
    assign bus.wb_en   = wb_en_c;
    assign bus.wb_addr = wb_addr_c;
    assign bus.wb_data = wb_data_c;
    assign bus.st_en   = st_en_c;
    assign bus.st_addr = st_en_c ? {alu_out[31:2], 2'b00} : 32'h0;
    assign bus.st_data = st_en_c ? b : 32'h0;
endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - self-checking bench with an instruction-level reference model
module tb_mips_multicycle;
    localparam int          IM_D = 256;
    localparam int          DM_D = 64;
    localparam logic [31:0] PCR  = 32'h0000_3000;
`ifdef MC_LINK_EN
    localparam bit LINK = 1'b1;
`else
    localparam bit LINK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_if bus();

    mips_multicycle #(.IM_DEPTH(IM_D), .DM_DEPTH(DM_D), .PC_RESET(PCR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural reference state
    logic [31:0] m_im [IM_D];
    logic [31:0] m_dm [DM_D];
    logic [31:0] m_r  [32];
    logic [31:0] m_pc;

    // Expected observation for the instruction being retired
    logic [31:0] e_pc;
    int          e_lat;
    logic        e_wb_en;
    logic [4:0]  e_wb_addr;
    logic [31:0] e_wb_data;
    logic        e_st_en;
    logic [31:0] e_st_addr;
    logic [31:0] e_st_data;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] w;
        w = 32'h0;
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:11] = 5'(rd);
        w[5:0]   = 6'(fn);
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int im);
        logic [31:0] w;
        w[31:26] = 6'(op);
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:0]  = 16'(im);
        return w;
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int tgt);
        logic [31:0] w;
        w[31:26] = 6'(op);
        w[25:0]  = 26'(tgt);
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
        for (int i = 0; i < DM_D; i++) m_dm[i] = 32'h0;
        m_pc = PCR;
    endtask

    // Executes one instruction architecturally and records what the core should show
    task automatic model_step();
        logic [31:0] ins, pc4, npc, sx, addr, wd;
        logic [5:0]  op, fn;
        int          rs, rt, rd, wa;
        bit          wr;
        ins = m_im[((m_pc - PCR) >> 2) % IM_D];
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = int'(ins[25:21]);
        rt  = int'(ins[20:16]);
        rd  = int'(ins[15:11]);
        sx  = {{16{ins[15]}}, ins[15:0]};
        pc4 = m_pc + 32'd4;
        npc = pc4;
        addr = m_r[rs] + sx;
        wr = 1'b0; wa = 0; wd = 32'h0;
        e_pc = m_pc; e_lat = 3; e_wb_en = 1'b0; e_st_en = 1'b0;
        e_wb_addr = 5'd0; e_wb_data = 32'h0; e_st_addr = 32'h0; e_st_data = 32'h0;
        case (op)
            6'h00: begin
                if (fn == 6'h21) begin wr = 1; wa = rd; wd = m_r[rs] + m_r[rt]; e_lat = 4; end
                else if (fn == 6'h23) begin wr = 1; wa = rd; wd = m_r[rs] - m_r[rt]; e_lat = 4; end
                else if (fn == 6'h08 && LINK) npc = m_r[rs];
            end
            6'h0d: begin wr = 1; wa = rt; wd = m_r[rs] | {16'h0, ins[15:0]}; e_lat = 4; end
            6'h0f: begin wr = 1; wa = rt; wd = {ins[15:0], 16'h0}; e_lat = 4; end
            6'h23: begin wr = 1; wa = rt; wd = m_dm[(addr >> 2) % DM_D]; e_lat = 5; end
            6'h2b: begin
                e_lat = 4; e_st_en = 1'b1;
                e_st_addr = {addr[31:2], 2'b00};
                e_st_data = m_r[rt];
                m_dm[(addr >> 2) % DM_D] = m_r[rt];
            end
            6'h04: if (m_r[rs] == m_r[rt]) npc = pc4 + (sx << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: if (LINK) begin npc = {pc4[31:28], ins[25:0], 2'b00}; wr = 1; wa = 31; wd = pc4; end
            default: ;
        endcase
        if (wr && wa != 0) begin
            e_wb_en = 1'b1; e_wb_addr = 5'(wa); e_wb_data = wd;
            m_r[wa] = wd;
        end
        m_pc = npc;
    endtask

    // Writes the whole model IM image into the core; run while reset is held
    task automatic load_im();
        for (int i = 0; i < IM_D; i++) begin
            bus.im_we    = 1'b1;
            bus.im_waddr = PCR + 32'(i * 4);
            bus.im_wdata = m_im[i];
            @(posedge clk); #1;
        end
        bus.im_we = 1'b0;
    endtask

    // Samples every negedge; the first sample is the FETCH cycle after release
    task automatic run(input int n);
        int cyc = 0;
        int done = 0;
        int guard = 0;
        while (done < n && guard < n * 6 + 10) begin
            @(negedge clk);
            guard++;
            cyc++;
            if (bus.retire) begin
                model_step();
                check("pc", bus.pc_o, e_pc);
                check("latency", 32'(cyc), 32'(e_lat));
                check("wb_en", 32'(bus.wb_en), 32'(e_wb_en));
                if (e_wb_en) begin
                    check("wb_addr", 32'(bus.wb_addr), 32'(e_wb_addr));
                    check("wb_data", bus.wb_data, e_wb_data);
                end
                check("st_en", 32'(bus.st_en), 32'(e_st_en));
                if (e_st_en) begin
                    check("st_addr", bus.st_addr, e_st_addr);
                    check("st_data", bus.st_data, e_st_data);
                end
                cyc = 0;
                done++;
            end else begin
                check("idle_wb_en", 32'(bus.wb_en), 32'h0);
                check("idle_st_en", 32'(bus.st_en), 32'h0);
                check("retire_overdue", 32'(cyc > 5), 32'h0);
            end
        end
        check("retire_count", 32'(done), 32'(n));
    endtask

    task automatic check_reset_outputs();
        check("rst_pc_o", bus.pc_o, PCR);
        check("rst_retire", 32'(bus.retire), 32'h0);
        check("rst_wb_en", 32'(bus.wb_en), 32'h0);
        check("rst_wb_addr", 32'(bus.wb_addr), 32'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_st_en", 32'(bus.st_en), 32'h0);
        check("rst_st_addr", bus.st_addr, 32'h0);
        check("rst_st_data", bus.st_data, 32'h0);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        int k  = $urandom_range(0, 11);
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        int rd = $urandom_range(0, 7);
        int im = $urandom_range(0, 65535);
        case (k)
            0:  return enc_r(rs, rt, rd, 6'h21);
            1:  return enc_r(rs, rt, rd, 6'h23);
            2:  return enc_i(6'h0d, rs, rt, im);
            3:  return enc_i(6'h23, rs, rt, im);
            4:  return enc_i(6'h2b, rs, rt, im);
            5:  return enc_i(6'h04, rs, rt, $urandom_range(0, 6) - 3);
            6:  return enc_i(6'h0f, rs, rt, im);
            7:  return enc_j(6'h02, int'($urandom));
            8:  return enc_j(6'h03, int'($urandom));
            9:  return enc_r(rs, 0, 0, 6'h08);
            10: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.im_we    = 1'b0;
        bus.im_waddr = 32'h0;
        bus.im_wdata = 32'h0;

        // Directed program
        for (int i = 0; i < IM_D; i++) m_im[i] = 32'h0;
        m_im[0]  = enc_i(6'h0d, 0, 1, 16'h1234);  // ori  $1,$0,0x1234
        m_im[1]  = enc_i(6'h0f, 0, 2, 16'hABCD);  // lui  $2,0xABCD
        m_im[2]  = enc_r(1, 2, 3, 6'h21);         // addu $3,$1,$2
        m_im[3]  = enc_i(6'h2b, 0, 3, 8);         // sw   $3,8($0)
        m_im[4]  = enc_i(6'h23, 0, 4, 8);         // lw   $4,8($0)
        m_im[5]  = enc_i(6'h04, 1, 0, 5);         // beq  $1,$0 (not taken)
        m_im[6]  = enc_j(6'h03, 32'h3100 >> 2);   // jal  0x3100
        m_im[7]  = enc_r(3, 1, 5, 6'h23);         // subu $5,$3,$1
        m_im[8]  = enc_i(6'h04, 1, 1, 16'hFFFF);  // beq  $1,$1,-1 (self loop)
        m_im[64] = enc_r(31, 0, 0, 6'h08);        // jr   $31 at 0x3100
        repeat (3) @(posedge clk);
        load_im();
        #1 check_reset_outputs();
        release_reset();
        run(16);

        // Reset during the MEM state of a store must leave DM untouched
        reset = 1'b1;
        for (int i = 0; i < IM_D; i++) m_im[i] = 32'h0;
        m_im[0] = enc_i(6'h23, 0, 5, 4);          // lw  $5,4($0)
        m_im[1] = enc_i(6'h0d, 0, 1, 16'h0055);   // ori $1,$0,0x55
        m_im[2] = enc_i(6'h2b, 0, 1, 4);          // sw  $1,4($0)
        m_im[3] = enc_i(6'h23, 0, 6, 4);          // lw  $6,4($0)
        m_im[4] = enc_i(6'h04, 0, 0, 16'hFFFF);   // beq $0,$0,-1
        load_im();
        release_reset();
        run(2);
        repeat (3) @(negedge clk);                // sw FETCH, DECODE, EXEC
        @(posedge clk); #1;                       // now in MEM of sw
        reset = 1'b1;
        #1;
        check("abort_st_en", 32'(bus.st_en), 32'h0);
        check("abort_retire", 32'(bus.retire), 32'h0);
        check("abort_pc_o", bus.pc_o, PCR);
        repeat (2) @(posedge clk);
        release_reset();
        run(7);

        // Randomized programs
        for (int round = 0; round < 4; round++) begin
            reset = 1'b1;
            for (int i = 0; i < IM_D; i++) m_im[i] = rand_instr();
            load_im();
            #1 check("rand_rst_pc_o", bus.pc_o, PCR);
            release_reset();
            run(80);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
